// File: rtl/axis_frame_gen.sv
// axis_frame_gen: AXI4-Stream test-frame source.
//
// Emits frames of fixed or pseudo-random byte length with a programmable
// idle gap between frames. The payload is either an incrementing byte
// pattern or an LFSR pattern. All AXIS outputs come straight from registers.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   enable             generate frames while high
//   cfg_rand_len       0 = fixed length (cfg_len), 1 = cfg_min_len + (lfsr & cfg_len)
//   cfg_len            fixed length in bytes, or random-mode mask
//   cfg_min_len        random-mode base length in bytes
//   cfg_gap            idle cycles between frames
//   cfg_payload        0 = incrementing bytes, 1 = LFSR words
//   m_axis_*           AXI4-Stream master (tdata lane 0 = first byte)
//   frame_count        completed frames, wraps modulo 2^32
//   busy               high while loading, sending or in the gap
module axis_frame_gen #(
    parameter int          DATA_BYTES = 4,
    parameter int          LEN_W      = 16,
    parameter int          GAP_W      = 16,
    parameter logic [31:0] LFSR_SEED  = 32'h0000_0001
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic                    cfg_rand_len,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic [LEN_W-1:0]        cfg_min_len,
    input  logic [GAP_W-1:0]        cfg_gap,
    input  logic                    cfg_payload,
    output logic [8*DATA_BYTES-1:0] m_axis_tdata,
    output logic [DATA_BYTES-1:0]   m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [31:0]             frame_count,
    output logic                    busy
);

    localparam int          DW        = 8 * DATA_BYTES;
    // One extra bit so offset/remaining arithmetic never overflows.
    localparam int          OFF_W     = LEN_W + 1;
    localparam logic [31:0] SEED_EFF  = (LFSR_SEED == 32'h0000_0000) ? 32'h0000_0001 : LFSR_SEED;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [OFF_W-1:0] BEAT_STEP = OFF_W'(DATA_BYTES);
    localparam logic [LEN_W-1:0] LEN_MAX   = {LEN_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Galois step for x^32+x^22+x^2+x+1 (right-shifting form).
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        lfsr_next = {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0000_0000);
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [31:0]        len_lfsr_r;
    logic [31:0]        dat_lfsr_r;
    logic [LEN_W-1:0]   len_r;
    logic [OFF_W-1:0]   off_r;
    logic [GAP_W-1:0]   gap_r;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic               payload_r;
    logic [DW-1:0]      tdata_r;
    logic [DATA_BYTES-1:0] tkeep_r;
    logic               tvalid_r;
    logic               tlast_r;
    logic [31:0]        frame_count_r;
    logic               busy_r;

    logic [LEN_W:0]     rand_sum_s;
    logic [LEN_W-1:0]   raw_len_s;
    logic [LEN_W-1:0]   load_len_s;
    logic               handshake_s;
    logic               frame_done_s;
    logic [31:0]        dat_lfsr_nxt_s;
    logic [OFF_W-1:0]   beat_off_s;
    logic [LEN_W-1:0]   beat_len_s;
    logic [31:0]        beat_lfsr_s;
    logic               beat_mode_s;
    logic [OFF_W-1:0]   remain_s;
    logic               beat_last_s;
    logic [DATA_BYTES-1:0] beat_keep_s;
    logic [DW-1:0]      beat_data_s;

    assign handshake_s    = tvalid_r & m_axis_tready;
    assign frame_done_s   = handshake_s & tlast_r;
    assign dat_lfsr_nxt_s = lfsr_next(dat_lfsr_r);

    // Frame length chosen at LOAD: saturating random sum, zero clamped to one byte.
    always_comb begin
        rand_sum_s = {1'b0, cfg_min_len} + {1'b0, (len_lfsr_r[LEN_W-1:0] & cfg_len)};
        raw_len_s  = cfg_len;
        if (cfg_rand_len) begin
            if (rand_sum_s[LEN_W]) begin
                raw_len_s = LEN_MAX;
            end else begin
                raw_len_s = rand_sum_s[LEN_W-1:0];
            end
        end else begin
            raw_len_s = cfg_len;
        end
        if (raw_len_s == {LEN_W{1'b0}}) begin
            load_len_s = {{(LEN_W-1){1'b0}}, 1'b1};
        end else begin
            load_len_s = raw_len_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_s = ST_SEND;
            end
            ST_SEND: begin
                if (frame_done_s) begin
                    if (gap_r != {GAP_W{1'b0}}) begin
                        state_s = ST_GAP;
                    end else if (enable) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == {{(GAP_W-1){1'b0}}, 1'b1}) begin
                    if (enable) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_GAP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Parameters of the beat to be registered next: the first beat in LOAD,
    // otherwise the beat following the one currently on the bus.
    always_comb begin
        beat_off_s  = off_r + BEAT_STEP;
        beat_len_s  = len_r;
        beat_lfsr_s = payload_r ? dat_lfsr_nxt_s : dat_lfsr_r;
        beat_mode_s = payload_r;
        case (state_r)
            ST_LOAD: begin
                beat_off_s  = {OFF_W{1'b0}};
                beat_len_s  = load_len_s;
                beat_lfsr_s = dat_lfsr_r;
                beat_mode_s = cfg_payload;
            end
            default: begin
                beat_off_s  = off_r + BEAT_STEP;
                beat_len_s  = len_r;
                beat_lfsr_s = payload_r ? dat_lfsr_nxt_s : dat_lfsr_r;
                beat_mode_s = payload_r;
            end
        endcase
    end

    // Beat contents: lanes past the end of the frame are disabled and zeroed.
    always_comb begin
        remain_s    = {1'b0, beat_len_s} - beat_off_s;
        beat_last_s = (remain_s <= BEAT_STEP);
        beat_keep_s = {DATA_BYTES{1'b0}};
        beat_data_s = {DW{1'b0}};
        for (int i = 0; i < DATA_BYTES; i++) begin
            beat_keep_s[i] = (remain_s > OFF_W'(i));
            if (!beat_keep_s[i]) begin
                beat_data_s[8*i +: 8] = 8'h00;
            end else if (beat_mode_s) begin
                beat_data_s[8*i +: 8] = beat_lfsr_s[8*(i%4) +: 8];
            end else begin
                beat_data_s[8*i +: 8] = 8'(beat_off_s) + 8'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath, LFSRs, counters and registered AXIS outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            len_lfsr_r    <= SEED_EFF;
            dat_lfsr_r    <= SEED_EFF;
            len_r         <= {LEN_W{1'b0}};
            off_r         <= {OFF_W{1'b0}};
            gap_r         <= {GAP_W{1'b0}};
            gap_cnt_r     <= {GAP_W{1'b0}};
            payload_r     <= 1'b0;
            tdata_r       <= {DW{1'b0}};
            tkeep_r       <= {DATA_BYTES{1'b0}};
            tvalid_r      <= 1'b0;
            tlast_r       <= 1'b0;
            frame_count_r <= 32'h0000_0000;
            busy_r        <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
            case (state_r)
                ST_LOAD: begin
                    len_r      <= load_len_s;
                    payload_r  <= cfg_payload;
                    gap_r      <= cfg_gap;
                    off_r      <= {OFF_W{1'b0}};
                    len_lfsr_r <= lfsr_next(len_lfsr_r);
                    tvalid_r   <= 1'b1;
                    tdata_r    <= beat_data_s;
                    tkeep_r    <= beat_keep_s;
                    tlast_r    <= beat_last_s;
                end
                ST_SEND: begin
                    if (handshake_s) begin
                        if (payload_r) begin
                            dat_lfsr_r <= dat_lfsr_nxt_s;
                        end
                        if (tlast_r) begin
                            frame_count_r <= frame_count_r + 32'h0000_0001;
                            gap_cnt_r     <= gap_r;
                            tvalid_r      <= 1'b0;
                            tdata_r       <= {DW{1'b0}};
                            tkeep_r       <= {DATA_BYTES{1'b0}};
                            tlast_r       <= 1'b0;
                        end else begin
                            off_r   <= beat_off_s;
                            tdata_r <= beat_data_s;
                            tkeep_r <= beat_keep_s;
                            tlast_r <= beat_last_s;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r != {GAP_W{1'b0}}) begin
                        gap_cnt_r <= gap_cnt_r - {{(GAP_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    tvalid_r <= 1'b0;
                    tdata_r  <= {DW{1'b0}};
                    tkeep_r  <= {DATA_BYTES{1'b0}};
                    tlast_r  <= 1'b0;
                end
            endcase
        end
    end

    assign m_axis_tdata  = tdata_r;
    assign m_axis_tkeep  = tkeep_r;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tlast  = tlast_r;
    assign frame_count   = frame_count_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed bench for axis_frame_gen with a 4-byte and an 8-byte instance.
module tb_axis_frame_gen;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic        cfg_rand_len;
    logic [15:0] cfg_len;
    logic [15:0] cfg_min_len;
    logic [15:0] cfg_gap;
    logic        cfg_payload;
    logic        tready;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic [31:0] fc;
    logic        busy;

    logic        en8;
    logic [15:0] len8;
    logic        tready8;
    logic [63:0] tdata8;
    logic [7:0]  tkeep8;
    logic        tvalid8;
    logic        tlast8;
    logic [31:0] fc8;
    logic        busy8;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axis_frame_gen #(.DATA_BYTES(4), .LEN_W(16), .GAP_W(16), .LFSR_SEED(32'h0000_0001)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .cfg_rand_len(cfg_rand_len),
        .cfg_len(cfg_len), .cfg_min_len(cfg_min_len), .cfg_gap(cfg_gap),
        .cfg_payload(cfg_payload), .m_axis_tdata(tdata), .m_axis_tkeep(tkeep),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast),
        .frame_count(fc), .busy(busy)
    );

    axis_frame_gen #(.DATA_BYTES(8), .LEN_W(16), .GAP_W(16), .LFSR_SEED(32'h0000_0001)) dut8 (
        .clk(clk), .resetn(resetn), .enable(en8), .cfg_rand_len(cfg_rand_len),
        .cfg_len(len8), .cfg_min_len(cfg_min_len), .cfg_gap(cfg_gap),
        .cfg_payload(cfg_payload), .m_axis_tdata(tdata8), .m_axis_tkeep(tkeep8),
        .m_axis_tvalid(tvalid8), .m_axis_tready(tready8), .m_axis_tlast(tlast8),
        .frame_count(fc8), .busy(busy8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lfsr_model(input logic [31:0] v);
        logic [31:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    // Accept one beat; optionally randomise tready and check hold/no-drop rules.
    task automatic recv_beat(input bit rnd, input bit mid,
                             output logic [31:0] d, output logic [3:0] k, output logic l);
        logic [36:0] prev;
        bit stalled;
        bit got;
        stalled = 1'b0;
        got     = 1'b0;
        prev    = 37'h0;
        d = 32'h0; k = 4'h0; l = 1'b0;
        for (int t = 0; t < 200 && !got; t++) begin
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mid || stalled) chk("vhold", {63'h0, tvalid}, 64'h1);
            if (tvalid) begin
                if (stalled) chk("stable", {27'h0, tdata, tkeep, tlast}, {27'h0, prev});
                if (tready) begin
                    d = tdata; k = tkeep; l = tlast;
                    got = 1'b1;
                end else begin
                    prev    = {tdata, tkeep, tlast};
                    stalled = 1'b1;
                end
            end
            step();
        end
        if (!got) chk("beat_timeout", 64'h0, 64'h1);
        tready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic [31:0] ed [3];
        logic [3:0]  ek [3];
        logic [31:0] m;
        int          cnt;
        int          bytes;
        int          exp_len;
        bit          done;

        ed[0] = 32'h0302_0100; ed[1] = 32'h0706_0504; ed[2] = 32'h0000_0908;
        ek[0] = 4'hF;          ek[1] = 4'hF;          ek[2] = 4'h3;

        resetn = 1'b0; enable = 1'b0; cfg_rand_len = 1'b0; cfg_payload = 1'b0;
        cfg_len = 16'd10; cfg_min_len = 16'd0; cfg_gap = 16'd0; tready = 1'b1;
        en8 = 1'b0; len8 = 16'd8; tready8 = 1'b1;
        repeat (3) step();

        // Reset state
        chk("rst_tvalid", {63'h0, tvalid}, 64'h0);
        chk("rst_tdata", {32'h0, tdata}, 64'h0);
        chk("rst_tkeep", {60'h0, tkeep}, 64'h0);
        chk("rst_tlast", {63'h0, tlast}, 64'h0);
        chk("rst_fc", {32'h0, fc}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_tvalid8", {63'h0, tvalid8}, 64'h0);
        resetn = 1'b1;
        step();

        // T1: fixed 10-byte frame, incrementing payload, latency from enable
        enable = 1'b1;
        step();
        chk("t1_busy_load", {63'h0, busy}, 64'h1);
        chk("t1_tvalid_load", {63'h0, tvalid}, 64'h0);
        enable = 1'b0;
        step();
        chk("t1_tvalid_send", {63'h0, tvalid}, 64'h1);
        for (int b = 0; b < 3; b++) begin
            recv_beat(1'b0, b != 0, d, k, l);
            chk("t1_data", {32'h0, d}, {32'h0, ed[b]});
            chk("t1_keep", {60'h0, k}, {60'h0, ek[b]});
            chk("t1_last", {63'h0, l}, {63'h0, (b == 2)});
        end
        chk("t1_fc", {32'h0, fc}, 64'd1);
        chk("t1_busy_end", {63'h0, busy}, 64'h0);
        chk("t1_tvalid_end", {63'h0, tvalid}, 64'h0);

        // T2: gap of 5 with enable held high
        cfg_gap = 16'd5;
        enable  = 1'b1;
        for (int b = 0; b < 3; b++) begin
            recv_beat(1'b0, b != 0, d, k, l);
        end
        chk("t2_a_last", {63'h0, l}, 64'h1);
        cnt = 0;
        for (int t = 0; t < 100 && !tvalid; t++) begin
            cnt++;
            step();
        end
        chk("t2_gap_cycles", cnt, 64'd6);
        enable = 1'b0;
        for (int b = 0; b < 3; b++) begin
            recv_beat(1'b0, b != 0, d, k, l);
            if (b == 0) chk("t2_b_first", {32'h0, d}, {32'h0, ed[0]});
        end
        chk("t2_b_keep", {60'h0, k}, 64'h3);
        chk("t2_b_last", {63'h0, l}, 64'h1);
        chk("t2_fc", {32'h0, fc}, 64'd3);
        for (int t = 0; t < 100 && busy; t++) step();
        chk("t2_idle", {63'h0, busy}, 64'h0);

        // T3: 64-byte LFSR frame with random tready
        cfg_gap = 16'd0; cfg_payload = 1'b1; cfg_len = 16'd64;
        enable = 1'b1;
        step();
        enable = 1'b0;
        m = 32'h0000_0001;
        for (int b = 0; b < 16; b++) begin
            recv_beat(1'b1, b != 0, d, k, l);
            chk("t3_data", {32'h0, d}, {32'h0, m});
            chk("t3_keep", {60'h0, k}, 64'hF);
            chk("t3_last", {63'h0, l}, {63'h0, (b == 15)});
            m = lfsr_model(m);
        end
        chk("t3_fc", {32'h0, fc}, 64'd4);

        // T4: 100 random-length frames from a fresh seed
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        step();
        cfg_payload = 1'b0; cfg_rand_len = 1'b1; cfg_min_len = 16'd16; cfg_len = 16'h007F;
        enable = 1'b1;
        m = 32'h0000_0001;
        for (int f = 0; f < 100; f++) begin
            exp_len = 16 + int'(m[15:0] & 16'h007F);
            m = lfsr_model(m);
            bytes = 0;
            done  = 1'b0;
            for (int b = 0; b < 64 && !done; b++) begin
                recv_beat(1'b0, b != 0, d, k, l);
                if (b == 0 && f == 99) enable = 1'b0;
                bytes += l ? $countones(k) : 4;
                done = l;
            end
            chk("t4_len", bytes, exp_len);
            chk("t4_range", {63'h0, (bytes >= 16 && bytes <= 143)}, 64'h1);
        end
        chk("t4_fc", {32'h0, fc}, 64'd100);
        for (int t = 0; t < 20 && busy; t++) step();

        // T5: zero length clamps to one byte; 8-byte instance full beat
        cfg_rand_len = 1'b0; cfg_len = 16'd0;
        enable = 1'b1;
        step();
        enable = 1'b0;
        recv_beat(1'b0, 1'b0, d, k, l);
        chk("t5_data", {32'h0, d}, 64'h0);
        chk("t5_keep", {60'h0, k}, 64'h1);
        chk("t5_last", {63'h0, l}, 64'h1);
        chk("t5_fc", {32'h0, fc}, 64'd101);
        en8 = 1'b1;
        step();
        en8 = 1'b0;
        for (int t = 0; t < 20 && !tvalid8; t++) step();
        chk("t5_v8", {63'h0, tvalid8}, 64'h1);
        chk("t5_data8", tdata8, 64'h0706_0504_0302_0100);
        chk("t5_keep8", {56'h0, tkeep8}, 64'hFF);
        chk("t5_last8", {63'h0, tlast8}, 64'h1);
        step();
        chk("t5_fc8", {32'h0, fc8}, 64'd1);

        // T6: drop enable mid-frame, then reset during the gap
        cfg_len = 16'd10; cfg_gap = 16'd5;
        enable = 1'b1;
        recv_beat(1'b0, 1'b0, d, k, l);
        chk("t6_first", {32'h0, d}, {32'h0, ed[0]});
        enable = 1'b0;
        recv_beat(1'b0, 1'b1, d, k, l);
        recv_beat(1'b0, 1'b1, d, k, l);
        chk("t6_keep", {60'h0, k}, 64'h3);
        chk("t6_last", {63'h0, l}, 64'h1);
        chk("t6_fc", {32'h0, fc}, 64'd102);
        step();
        step();
        chk("t6_gap_busy", {63'h0, busy}, 64'h1);
        chk("t6_gap_tvalid", {63'h0, tvalid}, 64'h0);
        resetn = 1'b0;
        #1;
        chk("t6_rst_tvalid", {63'h0, tvalid}, 64'h0);
        chk("t6_rst_busy", {63'h0, busy}, 64'h0);
        chk("t6_rst_fc", {32'h0, fc}, 64'h0);
        chk("t6_rst_out", {27'h0, tdata, tkeep, tlast}, 64'h0);
        chk("t6_rst_fc8", {32'h0, fc8}, 64'h0);
        step();
        resetn = 1'b1;
        step();
        chk("t6_post_busy", {63'h0, busy}, 64'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
